// File: rtl/window_gather_pkg.sv
// Shared types and helpers for the window gather block (window_gather, window_addr_gen).
package window_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        OUTPUT
    } state_e;

    localparam int unsigned DefMaxK = 3;

    function automatic int unsigned lane_count(input int unsigned max_k);
        return max_k * max_k;
    endfunction

    // Lane index width; kept at least 1 bit so a 1x1 configuration still elaborates.
    function automatic int unsigned lane_idx_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned max_k);
        return (k == 0 || k > max_k) ? max_k : k;
    endfunction

endpackage

// File: rtl/window_gather_addr_gen.sv
// Row/column walker for a KxK window: issues one buffer address per cycle in row-major order.
module window_addr_gen
    import window_pkg::*;
#(
    parameter int unsigned MaxK      = DefMaxK,
    parameter int unsigned AddrWidth = 6,
    parameter int unsigned KWidth    = $clog2(MaxK + 1),
    parameter int unsigned LaneW     = lane_idx_w(lane_count(MaxK))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AddrWidth-1:0] start_addr,
    input  logic [AddrWidth-1:0] row_stride,
    input  logic [KWidth-1:0]    k_size,
    output logic [AddrWidth-1:0] rd_addr,
    output logic                 rd_valid,
    output logic [LaneW-1:0]     lane_idx,
    output logic                 last_read
);

    logic                 active_q, active_d;
    logic [AddrWidth-1:0] row_base_q, row_base_d;
    logic [AddrWidth-1:0] stride_q, stride_d;
    logic [KWidth-1:0]    k_q, k_d;
    logic [KWidth-1:0]    r_q, r_d;
    logic [KWidth-1:0]    c_q, c_d;
    logic [LaneW-1:0]     lane_q, lane_d;
    logic [KWidth-1:0]    k_last;

    assign k_last    = k_q - KWidth'(1);
    assign last_read = active_q && (r_q == k_last) && (c_q == k_last);
    assign rd_addr   = row_base_q + AddrWidth'(c_q);
    assign rd_valid  = active_q;
    assign lane_idx  = lane_q;

    always_comb begin
        active_d   = active_q;
        row_base_d = row_base_q;
        stride_d   = stride_q;
        k_d        = k_q;
        r_d        = r_q;
        c_d        = c_q;
        lane_d     = lane_q;
        if (start) begin
            active_d   = 1'b1;
            row_base_d = start_addr;
            stride_d   = row_stride;
            k_d        = KWidth'(clamp_k(32'(k_size), MaxK));
            r_d        = '0;
            c_d        = '0;
            lane_d     = '0;
        end else if (active_q) begin
            lane_d = lane_q + LaneW'(1);
            if (last_read) begin
                active_d = 1'b0;
            end else if (c_q == k_last) begin
                // Row base accumulates the stride so no multiplier is needed.
                c_d        = '0;
                r_d        = r_q + KWidth'(1);
                row_base_d = row_base_q + stride_q;
            end else begin
                c_d = c_q + KWidth'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b0;
            row_base_q <= '0;
            stride_q   <= '0;
            k_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            lane_q     <= '0;
        end else begin
            active_q   <= active_d;
            row_base_q <= row_base_d;
            stride_q   <= stride_d;
            k_q        <= k_d;
            r_q        <= r_d;
            c_q        <= c_d;
            lane_q     <= lane_d;
        end
    end

endmodule

// File: rtl/window_gather.sv
// Local ifmap buffer plus KxK window gather into a packed lane vector with valid/ready output.
// Optional multi-window batching is enabled by defining BATCH_WINDOWS_EN.
module window_gather
    import window_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Depth     = 64,
    parameter int unsigned MaxK      = DefMaxK,
    parameter int unsigned AddrWidth = $clog2(Depth),
    parameter int unsigned KWidth    = $clog2(MaxK + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          writeEn,
    input  logic [AddrWidth-1:0]          writeAddr,
    input  logic [DataWidth-1:0]          dataIn,
    input  logic                          routeStart,
    input  logic [AddrWidth-1:0]          startAddr,
    input  logic [AddrWidth-1:0]          rowStride,
    input  logic [KWidth-1:0]             kSize,
`ifdef BATCH_WINDOWS_EN
    input  logic [AddrWidth-1:0]          numWindows,
    output logic                          lastWindow,
`endif
    output logic                          busy,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [MaxK*MaxK*DataWidth-1:0] dataOut
);

    localparam int unsigned Lanes = lane_count(MaxK);
    localparam int unsigned LaneW = lane_idx_w(Lanes);

    state_e               state_q, state_d;
    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rd_data_q, rd_data_d;
    logic [LaneW-1:0]     rd_lane_q, rd_lane_d;
    logic                 rd_vld_q, rd_vld_d;
    logic                 rd_last_q, rd_last_d;
    logic [DataWidth-1:0] lane_q [Lanes];
    logic [DataWidth-1:0] lane_d [Lanes];

    logic                 ag_start;
    logic [AddrWidth-1:0] ag_start_addr;
    logic [AddrWidth-1:0] ag_stride;
    logic [KWidth-1:0]    ag_k;
    logic [AddrWidth-1:0] ag_addr;
    logic                 ag_valid;
    logic [LaneW-1:0]     ag_lane;
    logic                 ag_last;

`ifdef BATCH_WINDOWS_EN
    logic [AddrWidth-1:0] base_q, base_d;
    logic [AddrWidth-1:0] stride_q, stride_d;
    logic [KWidth-1:0]    k_q, k_d;
    logic [AddrWidth-1:0] num_q, num_d;
    logic [AddrWidth-1:0] win_q, win_d;
    logic                 final_win;

    assign final_win  = (win_q == num_q - AddrWidth'(1));
    assign lastWindow = outValid && final_win;
`endif

    assign busy     = (state_q != IDLE);
    assign outValid = (state_q == OUTPUT);

    window_addr_gen #(
        .MaxK      (MaxK),
        .AddrWidth (AddrWidth),
        .KWidth    (KWidth),
        .LaneW     (LaneW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .start      (ag_start),
        .start_addr (ag_start_addr),
        .row_stride (ag_stride),
        .k_size     (ag_k),
        .rd_addr    (ag_addr),
        .rd_valid   (ag_valid),
        .lane_idx   (ag_lane),
        .last_read  (ag_last)
    );

    // Writes land on the same edge a start is sampled, so the first read already sees them.
    always_ff @(posedge clk) begin
        if (writeEn && !busy) begin
            mem_q[writeAddr] <= dataIn;
        end
    end

    always_comb begin
        state_d       = state_q;
        ag_start      = 1'b0;
        ag_start_addr = startAddr;
        ag_stride     = rowStride;
        ag_k          = kSize;
        rd_data_d     = mem_q[ag_addr];
        rd_lane_d     = ag_lane;
        rd_vld_d      = ag_valid;
        rd_last_d     = ag_last;
        lane_d        = lane_q;
`ifdef BATCH_WINDOWS_EN
        base_d        = base_q;
        stride_d      = stride_q;
        k_d           = k_q;
        num_d         = num_q;
        win_d         = win_q;
`endif
        if (rd_vld_q) begin
            lane_d[rd_lane_q] = rd_data_q;
        end
        case (state_q)
            IDLE: begin
                if (routeStart) begin
                    state_d  = GATHER;
                    ag_start = 1'b1;
                    for (int unsigned i = 0; i < Lanes; i++) lane_d[i] = '0;
`ifdef BATCH_WINDOWS_EN
                    base_d   = startAddr;
                    stride_d = rowStride;
                    k_d      = kSize;
                    num_d    = (numWindows == '0) ? AddrWidth'(1) : numWindows;
                    win_d    = '0;
`endif
                end
            end
            GATHER: begin
                if (rd_vld_q && rd_last_q) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (outReady) begin
`ifdef BATCH_WINDOWS_EN
                    if (final_win) begin
                        state_d = IDLE;
                    end else begin
                        // Next window restarts from the captured config, not the live ports.
                        state_d       = GATHER;
                        ag_start      = 1'b1;
                        ag_start_addr = base_q + AddrWidth'(1);
                        ag_stride     = stride_q;
                        ag_k          = k_q;
                        base_d        = base_q + AddrWidth'(1);
                        win_d         = win_q + AddrWidth'(1);
                        for (int unsigned i = 0; i < Lanes; i++) lane_d[i] = '0;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
            rd_lane_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            for (int unsigned i = 0; i < Lanes; i++) lane_q[i] <= '0;
`ifdef BATCH_WINDOWS_EN
            base_q    <= '0;
            stride_q  <= '0;
            k_q       <= '0;
            num_q     <= '0;
            win_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            rd_lane_q <= rd_lane_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            for (int unsigned i = 0; i < Lanes; i++) lane_q[i] <= lane_d[i];
`ifdef BATCH_WINDOWS_EN
            base_q    <= base_d;
            stride_q  <= stride_d;
            k_q       <= k_d;
            num_q     <= num_d;
            win_q     <= win_d;
`endif
        end
    end

    always_comb begin
        dataOut = '0;
        for (int unsigned j = 0; j < Lanes; j++) begin
            dataOut[j*DataWidth +: DataWidth] = lane_q[j];
        end
    end

endmodule

// File: tb/tb_window_gather.sv
// Directed self-checking bench for window_gather (default build; BATCH_WINDOWS_EN ports tied off).
module tb_window_gather;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 6;
    localparam int unsigned KW = 2;
    localparam int unsigned OW = 72;

    localparam logic [OW-1:0] ExpK3S0  = 72'h0C_0B_0A_07_06_05_02_01_00;
    localparam logic [OW-1:0] ExpK2S6  = 72'h00_00_00_00_00_0C_0B_07_06;
    localparam logic [OW-1:0] ExpWrap  = 72'h00_00_00_00_00_00_3F_3F_3E;
    localparam logic [OW-1:0] ExpNewWr = 72'h00_00_00_00_00_0C_0B_07_AA;
    localparam logic [OW-1:0] ExpPart3 = 72'h00_00_00_00_00_00_02_01_00;

    logic          clk = 1'b0;
    logic          rst;
    logic          writeEn;
    logic [AW-1:0] writeAddr;
    logic [DW-1:0] dataIn;
    logic          routeStart;
    logic [AW-1:0] startAddr;
    logic [AW-1:0] rowStride;
    logic [KW-1:0] kSize;
    logic          busy;
    logic          outValid;
    logic          outReady;
    logic [OW-1:0] dataOut;
`ifdef BATCH_WINDOWS_EN
    logic [AW-1:0] numWindows = 6'd1;
    logic          lastWindow;
`endif

    int checks   = 0;
    int failures = 0;

    window_gather #(
        .DataWidth (8),
        .Depth     (64),
        .MaxK      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .writeEn    (writeEn),
        .writeAddr  (writeAddr),
        .dataIn     (dataIn),
        .routeStart (routeStart),
        .startAddr  (startAddr),
        .rowStride  (rowStride),
        .kSize      (kSize),
`ifdef BATCH_WINDOWS_EN
        .numWindows (numWindows),
        .lastWindow (lastWindow),
`endif
        .busy       (busy),
        .outValid   (outValid),
        .outReady   (outReady),
        .dataOut    (dataOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_edge(input logic [AW-1:0] sa, input logic [AW-1:0] stride,
                              input logic [KW-1:0] k);
        startAddr  = sa;
        rowStride  = stride;
        kSize      = k;
        routeStart = 1'b1;
        tick();
        routeStart = 1'b0;
    endtask

    // Counts edges after the start edge until outValid; bounded so a stuck DUT still ends.
    task automatic wait_valid(input string tag, input int exp_edges);
        int cnt = 0;
        while (!outValid && cnt < 40) begin
            tick();
            cnt++;
        end
        check(tag, OW'(cnt), OW'(exp_edges));
    endtask

    task automatic handshake(input string tag);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        check({tag, "_valid_low"}, OW'(outValid), OW'(1'b0));
        check({tag, "_idle"}, OW'(busy), OW'(1'b0));
    endtask

    initial begin
        rst        = 1'b1;
        writeEn    = 1'b0;
        writeAddr  = '0;
        dataIn     = '0;
        routeStart = 1'b0;
        startAddr  = '0;
        rowStride  = '0;
        kSize      = '0;
        outReady   = 1'b0;
        tick();
        tick();
        check("rst_busy", OW'(busy), OW'(1'b0));
        check("rst_valid", OW'(outValid), OW'(1'b0));
        check("rst_data", dataOut, '0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            writeEn   = 1'b1;
            writeAddr = AW'(i);
            dataIn    = DW'(i);
            tick();
        end
        writeEn = 1'b0;

        // K=3 from 0, then hold the window for 20 cycles with outReady low
        start_edge(6'd0, 6'd5, 2'd3);
        check("k3_busy", OW'(busy), OW'(1'b1));
        wait_valid("k3_latency", 10);
        check("k3_data", dataOut, ExpK3S0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_valid", OW'(outValid), OW'(1'b1));
            check("hold_data", dataOut, ExpK3S0);
        end
        handshake("k3");

        start_edge(6'd6, 6'd5, 2'd2);
        wait_valid("k2_latency", 5);
        check("k2_data", dataOut, ExpK2S6);
        handshake("k2");

        start_edge(6'd62, 6'd1, 2'd2);
        wait_valid("wrap_latency", 5);
        check("wrap_data", dataOut, ExpWrap);
        handshake("wrap");

        start_edge(6'd0, 6'd5, 2'd0);
        wait_valid("k0_latency", 10);
        check("k0_clamp_data", dataOut, ExpK3S0);
        handshake("k0");

        // Busy: write, restart and config changes must all be ignored
        start_edge(6'd0, 6'd5, 2'd3);
        writeEn    = 1'b1;
        writeAddr  = 6'd1;
        dataIn     = 8'hFF;
        routeStart = 1'b1;
        startAddr  = 6'd30;
        kSize      = 2'd1;
        wait_valid("busy_latency", 10);
        writeEn    = 1'b0;
        routeStart = 1'b0;
        check("busy_data", dataOut, ExpK3S0);
        handshake("busy");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_second_win", OW'(busy), OW'(1'b0));
        end

        // Write and start on the same IDLE edge
        writeEn   = 1'b1;
        writeAddr = 6'd6;
        dataIn    = 8'hAA;
        start_edge(6'd6, 6'd5, 2'd2);
        writeEn = 1'b0;
        wait_valid("wr_start_latency", 5);
        check("wr_start_data", dataOut, ExpNewWr);
        handshake("wr_start");
        writeEn   = 1'b1;
        writeAddr = 6'd6;
        dataIn    = 8'h06;
        tick();
        writeEn = 1'b0;

        // Asynchronous reset in the middle of a gather
        start_edge(6'd0, 6'd5, 2'd3);
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy", OW'(busy), OW'(1'b1));
        check("mid_partial", dataOut, ExpPart3);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", OW'(busy), OW'(1'b0));
        check("arst_valid", OW'(outValid), OW'(1'b0));
        check("arst_data", dataOut, '0);
        tick();
        rst = 1'b0;

        start_edge(6'd6, 6'd5, 2'd2);
        wait_valid("post_rst_latency", 5);
        check("post_rst_data", dataOut, ExpK2S6);
        handshake("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
